// File: rtl/demux4_pkg.sv
// Shared constants for the demux4 stream block: default widths, channel codes
// and the FIFO pointer-width helper.
package demux4_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 2;
    localparam int CNT_W_DEF  = 8;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Pointer width for a power-of-two depth; depth 2 still needs one bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);

endpackage

// File: rtl/demux4_fifo.sv
// Per-channel synchronous FIFO with async active-high reset; head reads 0
// whenever the FIFO is empty.
module demux4_fifo
    import demux4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              do_push;
    logic              do_pop;

    // A pop never frees room for a push in the same cycle, so full blocks the push.
    assign full    = (occ == OCC_W'(DEPTH));
    assign empty   = (occ == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-2 stream demultiplexer with one FIFO per output channel.
// Optional saturating delivery counters are enabled by DEMUX4_STREAM_CNT_EN.
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;
    logic pop0, pop1;

    // Ready follows only the addressed channel, so a stalled channel never blocks the other.
    assign in_ready   = (in_sel == CH0) ? !full0 : !full1;
    assign push0      = in_valid && in_ready && (in_sel == CH0);
    assign push1      = in_valid && in_ready && (in_sel == CH1);
    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign pop0       = out0_valid && out0_ready;
    assign pop1       = out1_valid && out1_ready;

    demux4_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (in_data),
        .pop       (pop0),
        .full      (full0),
        .empty     (empty0),
        .head      (out0_data)
    );

    demux4_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in_data),
        .pop       (pop1),
        .full      (full1),
        .empty     (empty1),
        .head      (out1_data)
    );

`ifdef DEMUX4_STREAM_CNT_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (pop0 && (cnt0_q != '1)) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (pop1 && (cnt1_q != '1)) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: directed vector table, reset and
// counter sequences, then randomized traffic against a queue-based model.
module tb_demux4_stream;

    localparam int DATA_W  = 4;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out1_data;
    logic              out1_valid;
    logic              out1_ready;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic              sel;
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              r0;
        logic              r1;
        logic              exp_rdy;
        logic              exp_v0;
        logic [DATA_W-1:0] exp_d0;
        logic              exp_v1;
        logic [DATA_W-1:0] exp_d1;
    } vec_t;

    vec_t vecs [11];

    logic [DATA_W-1:0] q0 [$];
    logic [DATA_W-1:0] q1 [$];
    int n0;
    int n1;

    demux4_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    function automatic int exp_cnt(input int n);
`ifdef DEMUX4_STREAM_CNT_EN
        return (n > CNT_MAX) ? CNT_MAX : n;
`else
        return 0;
`endif
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic sel, input logic valid, input logic [DATA_W-1:0] data,
                                  input logic r0, input logic r1);
        in_sel     = sel;
        in_valid   = valid;
        in_data    = data;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, " in_ready"}, in_ready, 1);
        check_output({tag, " out0_valid"}, out0_valid, 0);
        check_output({tag, " out1_valid"}, out1_valid, 0);
        check_output({tag, " out0_data"}, out0_data, 0);
        check_output({tag, " out1_data"}, out1_data, 0);
        check_output({tag, " cnt0"}, cnt0, 0);
        check_output({tag, " cnt1"}, cnt1, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        n0 = 0;
        n1 = 0;
        tick();
    endtask

    initial begin
        // sel, valid, data, r0, r1 | pre-edge in_ready | post-edge v0, d0, v1, d1
        vecs[0]  = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 4'h0};
        vecs[1]  = '{1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h5};
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0};
        vecs[3]  = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0};
        vecs[4]  = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0};
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0};
        vecs[6]  = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 4'h3};
        vecs[7]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0};
        vecs[8]  = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 1'b0, 4'h0};
        vecs[9]  = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0};
        vecs[10] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0};

        do_reset();
        check_idle("reset");

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].r0, vecs[i].r1);
            #1;
            check_output($sformatf("row%0d in_ready", i), in_ready, vecs[i].exp_rdy);
            tick();
            check_output($sformatf("row%0d out0_valid", i), out0_valid, vecs[i].exp_v0);
            check_output($sformatf("row%0d out0_data", i), out0_data, vecs[i].exp_d0);
            check_output($sformatf("row%0d out1_valid", i), out1_valid, vecs[i].exp_v1);
            check_output($sformatf("row%0d out1_data", i), out1_data, vecs[i].exp_d1);
        end

        // Asynchronous reset with both channels holding words.
        apply_stimulus(1'b1, 1'b1, 4'hB, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 1'b1, 4'hC, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b1, 4'hD, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        check_output("prerst out0_data", out0_data, 4'hD);
        check_output("prerst out1_data", out1_data, 4'hB);
        check_output("prerst in_ready sel1", in_ready, 1);
        in_sel = 1'b1;
        #1;
        check_output("prerst in_ready full1", in_ready, 0);
        rst = 1'b1;
        #1;
        check_output("asyncrst out0_valid", out0_valid, 0);
        check_output("asyncrst out1_valid", out1_valid, 0);
        check_output("asyncrst out0_data", out0_data, 0);
        check_output("asyncrst out1_data", out1_data, 0);
        check_output("asyncrst cnt0", cnt0, 0);
        check_output("asyncrst cnt1", cnt1, 0);
        tick();
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        repeat (3) tick();
        check_idle("postrst");

        // Counter saturation on channel 1.
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(1'b1, 1'b1, 4'(i), 1'b1, 1'b1);
            tick();
        end
        apply_stimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        tick();
        check_output("sat cnt1", cnt1, exp_cnt(300));
        check_output("sat cnt0", cnt0, exp_cnt(0));
        check_output("sat out1_valid", out1_valid, 0);

        // Randomized traffic against the queue model.
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic              sel, valid, r0, r1, acc, p0, p1;
            logic [DATA_W-1:0] d;
            sel   = 1'($urandom_range(0, 1));
            valid = ($urandom_range(0, 3) != 0);
            d     = 4'($urandom);
            r0    = ($urandom_range(0, 3) != 0);
            r1    = ($urandom_range(0, 2) != 0);
            apply_stimulus(sel, valid, d, r0, r1);
            #1;
            acc = valid && ((sel ? q1.size() : q0.size()) < DEPTH);
            p0  = (q0.size() != 0) && r0;
            p1  = (q1.size() != 0) && r1;
            check_output($sformatf("rnd%0d in_ready", cyc), in_ready,
                         ((sel ? q1.size() : q0.size()) < DEPTH) ? 1 : 0);
            check_output($sformatf("rnd%0d out0_valid", cyc), out0_valid, (q0.size() != 0) ? 1 : 0);
            check_output($sformatf("rnd%0d out1_valid", cyc), out1_valid, (q1.size() != 0) ? 1 : 0);
            check_output($sformatf("rnd%0d out0_data", cyc), out0_data, (q0.size() != 0) ? int'(q0[0]) : 0);
            check_output($sformatf("rnd%0d out1_data", cyc), out1_data, (q1.size() != 0) ? int'(q1[0]) : 0);
            check_output($sformatf("rnd%0d cnt0", cyc), cnt0, exp_cnt(n0));
            check_output($sformatf("rnd%0d cnt1", cyc), cnt1, exp_cnt(n1));
            @(posedge clk);
            if (p0) begin
                void'(q0.pop_front());
                n0++;
            end
            if (p1) begin
                void'(q1.pop_front());
                n1++;
            end
            if (acc) begin
                if (sel) q1.push_back(d);
                else     q0.push_back(d);
            end
            #1;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
